// File: rtl/enemy_bullet_pool_if.sv
// Bus between an enemy's control logic / renderer and its bullet pool.
// With ENEMY_BULLET_STATS_EN defined the shot/retire counters are carried too.
interface enemy_bullet_pool_if #(
  parameter int unsigned NUM_BULLETS = 4
);
  localparam int unsigned IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  logic                        refresh_tick;
  logic [9:0]                  x;
  logic [9:0]                  y;
  logic                        fire_req;
  logic [1:0]                  fire_dir;
  logic [9:0]                  x_origin;
  logic [9:0]                  y_origin;
  logic [NUM_BULLETS-1:0]      hit_mask;
  logic                        kill_all;
  logic                        fire_ack;
  logic [NUM_BULLETS-1:0]      slot_active;
  logic [10*NUM_BULLETS-1:0]   x_bullet;
  logic [10*NUM_BULLETS-1:0]   y_bullet;
  logic                        bullet_on;
  logic [IDX_W-1:0]            bullet_on_idx;
`ifdef ENEMY_BULLET_STATS_EN
  logic [15:0]                 shot_count;
  logic [15:0]                 retire_count;

  modport master (
    output refresh_tick, x, y, fire_req, fire_dir, x_origin, y_origin, hit_mask, kill_all,
    input  fire_ack, slot_active, x_bullet, y_bullet, bullet_on, bullet_on_idx,
           shot_count, retire_count
  );
  modport slave (
    input  refresh_tick, x, y, fire_req, fire_dir, x_origin, y_origin, hit_mask, kill_all,
    output fire_ack, slot_active, x_bullet, y_bullet, bullet_on, bullet_on_idx,
           shot_count, retire_count
  );
`else
  modport master (
    output refresh_tick, x, y, fire_req, fire_dir, x_origin, y_origin, hit_mask, kill_all,
    input  fire_ack, slot_active, x_bullet, y_bullet, bullet_on, bullet_on_idx
  );
  modport slave (
    input  refresh_tick, x, y, fire_req, fire_dir, x_origin, y_origin, hit_mask, kill_all,
    output fire_ack, slot_active, x_bullet, y_bullet, bullet_on, bullet_on_idx
  );
`endif
endinterface

// File: rtl/enemy_bullet_pool.sv
// Pool of NUM_BULLETS enemy bullets with fire cooldown, movement, playfield
// retirement and a merged pixel-coverage flag for the VGA mux.
// Optional counters: define ENEMY_BULLET_STATS_EN to add shot_count/retire_count.
module enemy_bullet_pool #(
  parameter int unsigned NUM_BULLETS    = 4,
  parameter int unsigned BULLET_SIZE    = 4,
  parameter int unsigned SPRITE_SIZE    = 32,
  parameter int unsigned SPEED          = 4,
  parameter int unsigned COOLDOWN_TICKS = 8,
  parameter int unsigned X_MIN          = 32,
  parameter int unsigned X_MAX          = 607,
  parameter int unsigned Y_MIN          = 32,
  parameter int unsigned Y_MAX          = 447
) (
  input logic                clk_50MHz,
  input logic                reset,
  enemy_bullet_pool_if.slave bus
);
  localparam int unsigned IDX_W  = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int unsigned CD_W   = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [9:0]  MUZZLE = 10'((SPRITE_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] EDGE   = 11'(BULLET_SIZE - 1);
  localparam logic [10:0] XMIN   = 11'(X_MIN);
  localparam logic [10:0] XMAX   = 11'(X_MAX);
  localparam logic [10:0] YMIN   = 11'(Y_MIN);
  localparam logic [10:0] YMAX   = 11'(Y_MAX);

  typedef enum logic {SLOT_IDLE = 1'b0, SLOT_FLYING = 1'b1} slot_st_e;

  slot_st_e                    st_q  [NUM_BULLETS];
  slot_st_e                    st_d  [NUM_BULLETS];
  logic [1:0]                  dir_q [NUM_BULLETS];
  logic [1:0]                  dir_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0][9:0] x_q, x_d, y_q, y_d;
  logic [CD_W-1:0]             cd_q, cd_d;
  logic                        ack_q, ack_d;
  logic                        fire_ok, claimed, bnd_retire;
  logic [10:0]                 nx, ny;
`ifdef ENEMY_BULLET_STATS_EN
  logic [15:0]                 shot_q, shot_d, retire_q, retire_d;
`endif

  // State registers; everything clears on reset, including a pending ack.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        st_q[i]  <= SLOT_IDLE;
        dir_q[i] <= 2'b00;
      end
      x_q   <= '0;
      y_q   <= '0;
      cd_q  <= '0;
      ack_q <= 1'b0;
`ifdef ENEMY_BULLET_STATS_EN
      shot_q   <= '0;
      retire_q <= '0;
`endif
    end else begin
      st_q  <= st_d;
      dir_q <= dir_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cd_q  <= cd_d;
      ack_q <= ack_d;
`ifdef ENEMY_BULLET_STATS_EN
      shot_q   <= shot_d;
      retire_q <= retire_d;
`endif
    end
  end

  // Per-tick update: kill/hit retire first, flying slots move, then the
  // lowest slot that was idle at tick start (and not hit) may take a shot.
  always_comb begin
    st_d       = st_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    cd_d       = cd_q;
    ack_d      = 1'b0;
    claimed    = 1'b0;
    bnd_retire = 1'b0;
    nx         = '0;
    ny         = '0;
    fire_ok    = bus.fire_req && !bus.kill_all && (cd_q == '0);
`ifdef ENEMY_BULLET_STATS_EN
    shot_d   = shot_q;
    retire_d = retire_q;
`endif
    if (bus.refresh_tick) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (bus.kill_all || bus.hit_mask[i]) begin
          st_d[i] = SLOT_IDLE;
        end else if (st_q[i] == SLOT_FLYING) begin
          nx = {1'b0, x_q[i]};
          ny = {1'b0, y_q[i]};
          case (dir_q[i])
            2'b00:   ny = ny - SPD;
            2'b01:   ny = ny + SPD;
            2'b10:   nx = nx - SPD;
            default: nx = nx + SPD;
          endcase
          if (nx[10] || ny[10] || (nx < XMIN) || (ny < YMIN) ||
              ((nx + EDGE) > XMAX) || ((ny + EDGE) > YMAX)) begin
            st_d[i]    = SLOT_IDLE;
            bnd_retire = 1'b1;
          end else begin
            x_d[i] = nx[9:0];
            y_d[i] = ny[9:0];
          end
        end else if (fire_ok && !claimed) begin
          claimed  = 1'b1;
          st_d[i]  = SLOT_FLYING;
          dir_d[i] = bus.fire_dir;
          x_d[i]   = bus.x_origin + MUZZLE;
          y_d[i]   = bus.y_origin + MUZZLE;
        end
      end
      if (claimed) begin
        ack_d = 1'b1;
        cd_d  = CD_W'(COOLDOWN_TICKS);
      end else if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end
`ifdef ENEMY_BULLET_STATS_EN
      if (claimed && (shot_q != 16'hFFFF))      shot_d   = shot_q + 16'd1;
      if (bnd_retire && (retire_q != 16'hFFFF)) retire_d = retire_q + 16'd1;
`endif
    end
  end

  // Registered outputs onto the bus.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bus.slot_active[i] = (st_q[i] == SLOT_FLYING);
    end
    bus.x_bullet = x_q;
    bus.y_bullet = y_q;
    bus.fire_ack = ack_q;
`ifdef ENEMY_BULLET_STATS_EN
    bus.shot_count   = shot_q;
    bus.retire_count = retire_q;
`endif
  end

  // Pixel coverage; scanning downward lets the lowest covering slot win.
  always_comb begin
    bus.bullet_on     = 1'b0;
    bus.bullet_on_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if ((st_q[i] == SLOT_FLYING) &&
          ({1'b0, bus.x} >= {1'b0, x_q[i]}) && ({1'b0, bus.x} <= ({1'b0, x_q[i]} + EDGE)) &&
          ({1'b0, bus.y} >= {1'b0, y_q[i]}) && ({1'b0, bus.y} <= ({1'b0, y_q[i]} + EDGE))) begin
        bus.bullet_on     = 1'b1;
        bus.bullet_on_idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: doc/enemy_bullet_pool.md
Name: enemy_bullet_pool

Overview:
- Parametrised successor of the single-shot enemy projectile unit.
- Manages a pool of NUM_BULLETS independent enemy bullets per enemy, with a fire-rate cooldown, configurable speed and size, and playfield-bound retirement.
- Sits between an enemy's movement/direction logic and the VGA pixel mux.
- Provides per-slot positions for collision logic and a merged bullet_on pixel flag for the renderer.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..16)
BULLET_SIZE, 4, bullet square edge in pixels
SPRITE_SIZE, 32, enemy sprite edge; used for muzzle centring
SPEED, 4, pixels moved per refresh_tick
COOLDOWN_TICKS, 8, refresh ticks between accepted shots (0 = no cooldown)
X_MIN, 32, leftmost legal bullet pixel
X_MAX, 607, rightmost legal bullet pixel
Y_MIN, 32, topmost legal bullet pixel
Y_MAX, 447, bottommost legal bullet pixel

Ports:
clk_50MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
refresh_tick  in  1  one-cycle frame tick; all state updates happen only on it
x  in  10  current VGA pixel column
y  in  10  current VGA pixel row
fire_req  in  1  enemy requests a shot (level, sampled on refresh_tick)
fire_dir  in  2  shot direction: 00 up, 01 down, 10 left, 11 right
x_origin  in  10  enemy sprite left edge
y_origin  in  10  enemy sprite top edge
hit_mask  in  NUM_BULLETS  per-slot hit; retires the slot
kill_all  in  1  tank destroyed or level reset; retires all slots
fire_ack  out  1  one-cycle pulse when a shot is accepted
slot_active  out  NUM_BULLETS  per-slot in-flight flag
x_bullet  out  10*NUM_BULLETS  packed left edges; slot i at [10i+9:10i]
y_bullet  out  10*NUM_BULLETS  packed top edges
bullet_on  out  1  current pixel lies inside any active bullet
bullet_on_idx  out  IDX_W  lowest active slot covering the pixel; IDX_W = max(1, clog2(NUM_BULLETS))

Behaviour:
- Reset (async, reset=0):
  - all slots idle; x_bullet, y_bullet, slot_active = 0
  - cooldown counter = 0; fire_ack = 0
- Slot state per slot: IDLE or FLYING, plus a latched 2-bit direction.
- All updates occur on the clk_50MHz edge where refresh_tick=1. Without a tick, registers hold; only fire_ack clears.
- Per-tick priority, highest first:
  1. kill_all: all slots go IDLE; no fire accepted this tick; cooldown still decrements.
  2. hit_mask[i]: slot i goes IDLE. The freed slot is not reusable this same tick.
  3. Movement: each FLYING slot not hit moves SPEED pixels in its latched direction.
  4. Fire: accepted when fire_req=1, cooldown==0 (value before this tick's decrement), and at least one slot was IDLE at tick start and not hit.
- Fire acceptance:
  - Lowest-index free slot loads x = x_origin + (SPRITE_SIZE-BULLET_SIZE)/2 and y = y_origin + (SPRITE_SIZE-BULLET_SIZE)/2.
  - The slot latches fire_dir and goes FLYING.
  - A newly fired slot does not move on its firing tick.
  - fire_ack is high for exactly the cycle after the accepting edge.
  - cooldown loads COOLDOWN_TICKS.
- Cooldown: on a tick with no accepted fire, decrements by 1 when nonzero and saturates at 0. Net effect: with fire_req held, consecutive shots are COOLDOWN_TICKS+1 ticks apart.
- Movement arithmetic:
  - Computed 11 bits wide.
  - Retire (go IDLE, position held) if the next left edge < X_MIN, the next top edge < Y_MIN, the next left edge+BULLET_SIZE-1 > X_MAX, the next top edge+BULLET_SIZE-1 > Y_MAX, or the subtraction underflows (bit 10 set).
  - No wrap-around is ever visible on the outputs.
- Pool full (all slots FLYING) with fire_req: request dropped, no fire_ack, cooldown unchanged.
- Outputs of IDLE slots keep their last position; consumers must qualify with slot_active.
- bullet_on and bullet_on_idx are combinational from x, y and the registered state.
  - The inside test is inclusive: left ≤ x ≤ left+BULLET_SIZE-1, same for y.
  - bullet_on_idx = 0 when bullet_on=0.
- Reset asserted mid-flight: all slots clear immediately; no ack is produced.

Optional Feature:
ENEMY_BULLET_STATS_EN
- Defined:
  - Adds output shot_count [15:0]. It increments on every accepted fire and saturates at 16'hFFFF.
  - Adds output retire_count [15:0]. It increments once per tick in which ≥1 slot retires by boundary (hits and kill_all not counted) and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, origin (100,200), fire_dir=11, fire_req=1, one tick → slot_active=0001, slot0 at (114,214), fire_ack pulse 1 cycle; next tick slot0 x=118, y=214.
2. fire_req held, cooldown 8 → shots accepted at ticks 1 and 10 only; fire_ack seen exactly twice; slots 0 and 1 used.
3. Four slots FLYING, cooldown=0, fire_req=1 → no fire_ack, slot_active stays 1111, cooldown stays 0.
4. Slot0 dir=00 at y=34 → tick → slot_active[0]=0, y_bullet[0] stays 34. Slot1 dir=10 at x=2 (bounds X_MIN=0 build) → underflow → retired.
5. Slot1 FLYING, others FLYING, hit_mask=0010 with fire_req on same tick → slot1 IDLE, no fire that tick; next tick fire lands in slot1. Then kill_all with fire_req → slot_active=0000, no ack.
6. Slot0 at (114,214): pixel (117,217) → bullet_on=1, idx=0; pixel (118,217) → bullet_on=0, idx=0. Overlapping slots 1 and 2 → idx=1.
